// File: rtl/asa_ex_mdu_ctrl.sv
// asa_ex_mdu_ctrl: EX-stage sequencer for the multicycle MUL/DIV units.
// Accepts one M-extension op at a time. It resolves divide-by-zero and
// signed-overflow divisions locally. Any other op goes to the proper unit,
// and the result is held until WB takes it.
module asa_ex_mdu_ctrl #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned OPW     = 7,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [OPW-1:0]  operator_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            flush_i,
   output logic            mul_start_o,
   output logic            div_start_o,
   output logic [OPW-1:0]  unit_op_o,
   output logic [XLEN-1:0] unit_a_o,
   output logic [XLEN-1:0] unit_b_o,
   input  logic            mul_done_i,
   input  logic            div_done_i,
   input  logic [XLEN-1:0] mul_result_i,
   input  logic [XLEN-1:0] div_result_i,
   output logic            wb_valid_o,
   input  logic            wb_ready_i,
   output logic [XLEN-1:0] wb_data_o,
   output logic [4:0]      wb_addr_o,
   output logic            busy_o,
   output logic [4:0]      busy_rd_o,
   output logic            timeout_o
);

   // Operator encodings shared with the ALU decoder
   localparam logic [OPW-1:0] ALU_MUL    = OPW'(40);
   localparam logic [OPW-1:0] ALU_MULH   = OPW'(41);
   localparam logic [OPW-1:0] ALU_MULHSU = OPW'(42);
   localparam logic [OPW-1:0] ALU_MULHU  = OPW'(43);
   localparam logic [OPW-1:0] ALU_DIV    = OPW'(44);
   localparam logic [OPW-1:0] ALU_DIVU   = OPW'(45);
   localparam logic [OPW-1:0] ALU_REM    = OPW'(46);
   localparam logic [OPW-1:0] ALU_REMU   = OPW'(47);

   localparam logic [7:0]      TO_LIM  = 8'(TIMEOUT);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_HOLD} state_e;

   state_e          state_q, state_d;
   logic [OPW-1:0]  op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [4:0]      rd_q, rd_d;
   logic            sel_div_q, sel_div_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            timeout_q, timeout_d;

   logic            is_m_op, is_mul_op;
   logic            spec_hit;
   logic [XLEN-1:0] spec_res;
   logic            b_zero, div_ovf;

   // Classify the incoming operator and spot the cases resolved without the divider
   always_comb begin
      is_m_op   = 1'b0;
      is_mul_op = 1'b0;
      spec_hit  = 1'b0;
      spec_res  = '0;
      b_zero    = (operand_b_i == '0);
      div_ovf   = (operand_a_i == MIN_NEG) && (operand_b_i == '1);
      case (operator_i)
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: begin
            is_m_op   = 1'b1;
            is_mul_op = 1'b1;
         end
         ALU_DIV: begin
            is_m_op = 1'b1;
            if (b_zero) begin
               spec_hit = 1'b1;
               spec_res = '1;
            end else if (div_ovf) begin
               spec_hit = 1'b1;
               spec_res = operand_a_i;
            end
         end
         ALU_DIVU: begin
            is_m_op = 1'b1;
            if (b_zero) begin
               spec_hit = 1'b1;
               spec_res = '1;
            end
         end
         ALU_REM: begin
            is_m_op = 1'b1;
            if (b_zero) begin
               spec_hit = 1'b1;
               spec_res = operand_a_i;
            end else if (div_ovf) begin
               spec_hit = 1'b1;
               spec_res = '0;
            end
         end
         ALU_REMU: begin
            is_m_op = 1'b1;
            if (b_zero) begin
               spec_hit = 1'b1;
               spec_res = operand_a_i;
            end
         end
         default: ;
      endcase
   end

   logic            sel_done;
   logic [XLEN-1:0] sel_result;
   logic [7:0]      cnt_inc;
   logic            hit_to;

   // Next-state logic. A done that coincides with a flush in WAIT is dropped,
   // and the FSM returns to IDLE because nothing is left to drain.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      rd_d       = rd_q;
      sel_div_d  = sel_div_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      sel_done   = sel_div_q ? div_done_i : mul_done_i;
      sel_result = sel_div_q ? div_result_i : mul_result_i;
      cnt_inc    = cnt_q + 8'd1;
      hit_to     = (cnt_inc == TO_LIM);
      case (state_q)
         S_IDLE: begin
            if (req_valid_i && is_m_op) begin
               op_d      = operator_i;
               a_d       = operand_a_i;
               b_d       = operand_b_i;
               rd_d      = rd_addr_i;
               sel_div_d = !is_mul_op;
               if (spec_hit) begin
                  data_d  = spec_res;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = flush_i ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (flush_i) begin
               state_d = sel_done ? S_IDLE : S_DRAIN;
            end else if (sel_done) begin
               data_d  = sel_result;
               state_d = S_HOLD;
            end else if (hit_to) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_DRAIN: begin
            cnt_d = cnt_inc;
            if (sel_done) begin
               state_d = S_IDLE;
            end else if (hit_to) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_HOLD: begin
            if (flush_i || wb_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rd_q      <= '0;
         sel_div_q <= 1'b0;
         data_q    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rd_q      <= rd_d;
         sel_div_q <= sel_div_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign mul_start_o = (state_q == S_ISSUE) && !sel_div_q;
   assign div_start_o = (state_q == S_ISSUE) && sel_div_q;
   assign wb_valid_o  = (state_q == S_HOLD);
   assign unit_op_o   = op_q;
   assign unit_a_o    = a_q;
   assign unit_b_o    = b_q;
   assign wb_data_o   = data_q;
   assign wb_addr_o   = rd_q;
   assign busy_rd_o   = rd_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_asa_ex_mdu_ctrl.sv
// Bench for asa_ex_mdu_ctrl. It plays ID, both arithmetic units and WB.
// Expected results come from plain RISC-V M-extension arithmetic.
module tb_asa_ex_mdu_ctrl;

   localparam int TO = 8;
   localparam logic [6:0] OP_MUL    = 7'd40;
   localparam logic [6:0] OP_MULH   = 7'd41;
   localparam logic [6:0] OP_MULHSU = 7'd42;
   localparam logic [6:0] OP_MULHU  = 7'd43;
   localparam logic [6:0] OP_DIV    = 7'd44;
   localparam logic [6:0] OP_DIVU   = 7'd45;
   localparam logic [6:0] OP_REM    = 7'd46;
   localparam logic [6:0] OP_REMU   = 7'd47;
   localparam logic [6:0] OP_ADD    = 7'd3;

   logic        clk, rst;
   logic        req_valid_i, req_ready_o;
   logic [6:0]  operator_i;
   logic [31:0] operand_a_i, operand_b_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i, mul_start_o, div_start_o;
   logic [6:0]  unit_op_o;
   logic [31:0] unit_a_o, unit_b_o;
   logic        mul_done_i, div_done_i;
   logic [31:0] mul_result_i, div_result_i;
   logic        wb_valid_o, wb_ready_i;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_addr_o;
   logic        busy_o;
   logic [4:0]  busy_rd_o;
   logic        timeout_o;

   int   checks = 0;
   int   errors = 0;
   logic expTimeout = 1'b0;

   asa_ex_mdu_ctrl #(.XLEN(32), .OPW(7), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .rd_addr_i(rd_addr_i), .flush_i(flush_i),
      .mul_start_o(mul_start_o), .div_start_o(div_start_o),
      .unit_op_o(unit_op_o), .unit_a_o(unit_a_o), .unit_b_o(unit_b_o),
      .mul_done_i(mul_done_i), .div_done_i(div_done_i),
      .mul_result_i(mul_result_i), .div_result_i(div_result_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o),
      .busy_o(busy_o), .busy_rd_o(busy_rd_o), .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when the observed value differs
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic logic [31:0] riscvM(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ps;
      logic [63:0]        pu;
      logic signed [31:0] sa, sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      riscvM = '0;
      case (op)
         OP_MUL:    riscvM = a * b;
         OP_MULH:   begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); riscvM = ps[63:32]; end
         OP_MULHSU: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); riscvM = ps[63:32]; end
         OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; riscvM = pu[63:32]; end
         OP_DIV:    riscvM = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         OP_DIVU:   riscvM = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    riscvM = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         OP_REMU:   riscvM = (b == 0) ? a : a % b;
         default:   riscvM = '0;
      endcase
   endfunction

   function automatic logic isSpecial(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      isSpecial = ((op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) && b == 0) ||
                  ((op == OP_DIV || op == OP_REM) && ovf);
   endfunction

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_req_ready"}, req_ready_o, 1);
      checkOutput({tag, "_busy"}, busy_o, 0);
      checkOutput({tag, "_wb_valid"}, wb_valid_o, 0);
      checkOutput({tag, "_timeout"}, timeout_o, expTimeout);
   endtask

   // One full transaction. flushMode: 0 none, 1 in ISSUE, 2 in WAIT cycle flushAt,
   // 3 in HOLD cycle flushAt, 4 together with the request in IDLE. lat=0 means no done.
   task automatic applyStimulus(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input int lat, input int hold,
                                input int flushMode, input int flushAt);
      logic [31:0] exp;
      logic        spec, mulSel, drained, finished, timedOut, doneNow;
      int          k;
      exp    = riscvM(op, a, b);
      spec   = isSpecial(op, a, b);
      mulSel = (op >= OP_MUL) && (op <= OP_MULHU);
      checkOutput("pre_req_ready", req_ready_o, 1);
      req_valid_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b; rd_addr_i = rd;
      if (flushMode == 4) flush_i = 1'b1;
      step();
      flush_i = 1'b0; req_valid_i = 1'b0;
      operand_a_i = $urandom; operand_b_i = $urandom; rd_addr_i = 5'($urandom);
      checkOutput("acc_busy", busy_o, 1);
      checkOutput("acc_req_ready", req_ready_o, 0);
      checkOutput("busy_rd", busy_rd_o, rd);
      checkOutput("unit_op", unit_op_o, op);
      checkOutput("unit_a", unit_a_o, a);
      checkOutput("unit_b", unit_b_o, b);
      if (!spec) begin
         checkOutput("issue_mul_start", mul_start_o, mulSel);
         checkOutput("issue_div_start", div_start_o, !mulSel);
         checkOutput("issue_wb_valid", wb_valid_o, 0);
         drained = (flushMode == 1);
         if (flushMode == 1) flush_i = 1'b1;
         step();
         flush_i = 1'b0;
         k = 1; finished = 1'b0; timedOut = 1'b0;
         while (!finished && k <= TO + 2) begin
            checkOutput("wait_mul_start", mul_start_o, 0);
            checkOutput("wait_div_start", div_start_o, 0);
            checkOutput("wait_wb_valid", wb_valid_o, 0);
            checkOutput("wait_busy", busy_o, 1);
            checkOutput("wait_timeout", timeout_o, expTimeout);
            doneNow = (lat == k);
            if (doneNow) begin
               if (mulSel) begin mul_done_i = 1'b1; mul_result_i = exp; end
               else        begin div_done_i = 1'b1; div_result_i = exp; end
            end else if ($urandom_range(0, 3) == 0) begin
               if (mulSel) begin div_done_i = 1'b1; div_result_i = $urandom; end
               else        begin mul_done_i = 1'b1; mul_result_i = $urandom; end
            end
            if (flushMode == 2 && k == flushAt) begin flush_i = 1'b1; drained = 1'b1; end
            step();
            mul_done_i = 1'b0; div_done_i = 1'b0; flush_i = 1'b0;
            if (doneNow) finished = 1'b1;
            else if (k == TO) begin finished = 1'b1; timedOut = 1'b1; expTimeout = 1'b1; end
            k++;
         end
         checkOutput("wait_bounded", finished, 1);
         if (timedOut || drained || !finished) begin
            checkIdle(timedOut ? "after_timeout" : "after_drain");
            return;
         end
      end else begin
         checkOutput("spec_mul_start", mul_start_o, 0);
         checkOutput("spec_div_start", div_start_o, 0);
      end
      for (int h = 0; h <= hold; h++) begin
         checkOutput("hold_wb_valid", wb_valid_o, 1);
         checkOutput("hold_wb_data", wb_data_o, exp);
         checkOutput("hold_wb_addr", wb_addr_o, rd);
         checkOutput("hold_req_ready", req_ready_o, 0);
         checkOutput("hold_busy", busy_o, 1);
         if (flushMode == 3 && h == flushAt) begin
            req_valid_i = 1'b0;
            flush_i = 1'b1; wb_ready_i = 1'($urandom_range(0, 1));
            step();
            flush_i = 1'b0; wb_ready_i = 1'b0;
            checkIdle("after_hold_flush");
            return;
         end
         req_valid_i = (flushMode != 3); operator_i = OP_MUL; operand_a_i = 1; operand_b_i = 1;
         wb_ready_i  = (h == hold);
         step();
      end
      wb_ready_i = 1'b0; req_valid_i = 1'b0;
      checkIdle("after_handoff");
   endtask

   initial begin
      logic [6:0]  op;
      logic [31:0] a, b;
      int          r, lat, hold, fm, fa;
      rst = 1'b1; req_valid_i = 0; operator_i = 0; operand_a_i = 0; operand_b_i = 0;
      rd_addr_i = 0; flush_i = 0; mul_done_i = 0; div_done_i = 0; mul_result_i = 0;
      div_result_i = 0; wb_ready_i = 0;
      step(); step();
      checkIdle("reset");
      checkOutput("reset_starts", {30'b0, mul_start_o, div_start_o}, 0);
      checkOutput("reset_wb_data", wb_data_o, 0);
      checkOutput("reset_busy_rd", busy_rd_o, 0);
      rst = 1'b0;
      step();

      $display("[TB] non-M operator is ignored");
      req_valid_i = 1'b1; operator_i = OP_ADD; operand_a_i = 5; operand_b_i = 0;
      step();
      req_valid_i = 1'b0;
      checkIdle("non_m");
      checkOutput("non_m_starts", {30'b0, mul_start_o, div_start_o}, 0);

      $display("[TB] directed cases");
      applyStimulus(OP_MUL, 7, 6, 5, 3, 0, 0, 0);
      applyStimulus(OP_DIVU, 100, 0, 3, 1, 0, 0, 0);
      applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 9, 1, 0, 0, 0);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1, 1, 0, 0);
      applyStimulus(OP_REMU, 77, 0, 11, 1, 0, 0, 0);
      applyStimulus(OP_DIV, 20, 4, 12, 2, 5, 0, 0);
      applyStimulus(OP_MUL, 3, 9, 13, 5, 0, 2, 2);
      applyStimulus(OP_DIVU, 50, 7, 14, 3, 0, 2, 3);
      applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 15, 4, 0, 1, 0);
      applyStimulus(OP_REM, 32'hFFFF_FFF9, 2, 16, 2, 2, 3, 1);
      applyStimulus(OP_MULH, 32'h8000_0000, 2, 17, 1, 0, 4, 0);
      applyStimulus(OP_DIV, 20, 4, 18, 0, 0, 0, 0);
      checkOutput("timeout_sticky", timeout_o, 1);

      $display("[TB] randomized cases");
      for (int i = 0; i < 40; i++) begin
         op = OP_MUL + 7'($urandom_range(0, 7));
         r  = $urandom_range(0, 3);
         a  = (r == 0) ? 32'h8000_0000 : $urandom;
         r  = $urandom_range(0, 4);
         b  = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : (r == 2) ? 32'($urandom_range(1, 15)) : $urandom;
         lat  = $urandom_range(1, 6);
         hold = $urandom_range(0, 3);
         fm   = $urandom_range(0, 7);
         if (fm > 4) fm = 0;
         fa = (fm == 2) ? $urandom_range(1, lat) : (fm == 3) ? $urandom_range(0, hold) : 0;
         applyStimulus(op, a, b, 5'($urandom), lat, hold, fm, fa);
      end

      $display("[TB] reset in the middle of WAIT");
      req_valid_i = 1'b1; operator_i = OP_DIV; operand_a_i = 20; operand_b_i = 4; rd_addr_i = 7;
      step();
      req_valid_i = 1'b0;
      step(); step();
      checkOutput("pre_rst_busy", busy_o, 1);
      #3 rst = 1'b1;
      #1;
      expTimeout = 1'b0;
      checkIdle("async_rst");
      checkOutput("async_rst_unit_a", unit_a_o, 0);
      checkOutput("async_rst_busy_rd", busy_rd_o, 0);
      step();
      rst = 1'b0;
      div_done_i = 1'b1; div_result_i = 5;
      step();
      div_done_i = 1'b0;
      checkIdle("stray_done");
      step();
      checkIdle("stray_done_2");
      applyStimulus(OP_DIV, 20, 4, 7, 2, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/asa_ex_mdu_ctrl.md
Name: asa_ex_mdu_ctrl

Overview:
- Sequencer between the ID/EX handoff and the multicycle MUL and DIV units in the EX stage.
- Accepts one M-extension operation at a time and starts the proper unit. Waits for its completion, then holds the result until WB accepts it.
- Drives the EX stall term and a busy-rd scoreboard to ID.
- Resolves RISC-V divide-by-zero and signed-overflow cases itself in one cycle without starting the divider.

Parameters:
- XLEN, 32, datapath width.
- OPW, 7, operator width (matches ALU_OP_WIDTH).
- TIMEOUT, 64, maximum cycles in WAIT before error; range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  ID presents an M-op this cycle
- req_ready_o  out  1  controller can accept a request
- operator_i  in  OPW  ALU_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
- operand_a_i  in  XLEN  rs1 value
- operand_b_i  in  XLEN  rs2 value
- rd_addr_i  in  5  destination register
- flush_i  in  1  kill the in-flight operation (branch taken)
- mul_start_o  out  1  one-cycle start pulse to multiplier
- div_start_o  out  1  one-cycle start pulse to divider
- unit_op_o  out  OPW  registered operator to units
- unit_a_o  out  XLEN  registered operand A
- unit_b_o  out  XLEN  registered operand B
- mul_done_i  in  1  multiplier result valid (pulse)
- div_done_i  in  1  divider result valid (pulse)
- mul_result_i  in  XLEN  multiplier result
- div_result_i  in  XLEN  divider result
- wb_valid_o  out  1  result available to WB
- wb_ready_i  in  1  WB accepts the result
- wb_data_o  out  XLEN  result data
- wb_addr_o  out  5  destination register
- busy_o  out  1  operation in flight; feeds ex_ready
- busy_rd_o  out  5  rd of in-flight op; valid when busy_o=1
- timeout_o  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0, except req_ready_o=1.
  - timeout counter cleared.
- States: IDLE, ISSUE, WAIT, DRAIN, HOLD.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i=1 with a non-M operator: request ignored, no state change.
  - On req_valid_i with an M operator: capture operator, operands and rd into the unit_* and rd registers.
  - Special-case check on the captured values:
    - DIV/DIVU, b==0: result all-ones.
    - REM/REMU, b==0: result = a.
    - DIV, a==0x80000000 and b==all-ones: result a.
    - REM, same overflow operands: result 0.
  - Special case goes straight to HOLD with the result loaded; no unit start. Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - Pulse mul_start_o or div_start_o for exactly one cycle, then go to WAIT.
  - Never both starts in one cycle.
- WAIT:
  - Count cycles.
  - done of the selected unit → latch its result into wb_data_o, go to HOLD.
  - done of the non-selected unit is ignored.
  - Count reaching TIMEOUT → set timeout_o (sticky until reset), go to IDLE, no WB write.
- HOLD:
  - wb_valid_o=1; wb_data_o/wb_addr_o stable.
  - On wb_ready_i=1: clear wb_valid_o next cycle and go to IDLE.
  - Minimum latency, request to wb_valid_o:
    - special case: 1 cycle;
    - unit op: 2 + unit latency.
- busy_o=1 in every state except IDLE. req_ready_o=0 outside IDLE.
- Back-to-back: a request presented in the cycle HOLD hands off is not accepted. It is accepted the next cycle, in IDLE.
- flush_i:
  - In ISSUE: start still pulses (units cannot abort); go to DRAIN.
  - In WAIT: go to DRAIN.
  - In HOLD: drop the result, go to IDLE, no WB handshake.
  - In IDLE: no effect. A request in the same cycle is accepted.
  - DRAIN: busy_o=1, wb_valid_o=0. Wait for the selected unit's done (or TIMEOUT), discard the result, go to IDLE.
- Done arriving in the same cycle as flush_i in WAIT: flush wins, result discarded.
- Operands are registered at acceptance. Changes on operand_*_i after acceptance have no effect.
- Reset mid-operation: immediate return to reset values. Any later stray done is ignored in IDLE.

Test Plan:
- MUL 7×6, rd=5, mul_done 3 cycles after start, wb_ready=1 → one mul_start pulse, wb_valid with data 42, addr 5, busy_o low the cycle after handshake.
- DIVU 100/0, rd=3 → no div_start; wb_valid the cycle after the request, data 0xFFFFFFFF. REM 0x80000000 % 0xFFFFFFFF → data 0.
- DIV 20/4, wb_ready held low 5 cycles → wb_valid, data 5 and addr stable for all 5 cycles; a new req_valid meanwhile sees req_ready_o=0.
- MUL issued, flush_i in the 2nd WAIT cycle, mul_done later → no wb_valid, busy_o stays 1 until done, then 0.
- TIMEOUT=8, DIV started, div_done never arrives → timeout_o=1 after 8 WAIT cycles, return to IDLE, timeout_o persists until rst.
- rst asserted mid-WAIT → outputs reset asynchronously; a later div_done produces no wb_valid.
